// File: rtl/m_gen_sec.sv
// m_gen_sec: divides the board clock to a 1 Hz tick, keeps BCD seconds 00-59 and
// pulses clk_min on the 59->00 wrap. Define M_GEN_SEC_BLINK_EN to build the colon blink.
module m_gen_sec #(
    parameter int CLK_DIV = 50_000_000,
    parameter int DIV_W   = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_low,
    input  logic [3:0] load_high,
    output logic [3:0] sec_low,
    output logic [3:0] sec_high,
    output logic       tick_1hz,
    output logic       clk_min,
    output logic       blink
);
    localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

    function automatic logic [3:0] clamp_bcd(input logic [3:0] val, input logic [3:0] lim);
        if (val > lim) begin
            return lim;
        end else begin
            return val;
        end
    endfunction

    logic [DIV_W-1:0] div_cnt_r, div_cnt_s;
    logic [3:0]       sec_low_r, sec_low_s;
    logic [3:0]       sec_high_r, sec_high_s;
    logic             tick_r, tick_s;
    logic             min_r, min_s;

    // Next-state selection in priority order clr > load > count > hold
    always_comb begin
        div_cnt_s  = div_cnt_r;
        sec_low_s  = sec_low_r;
        sec_high_s = sec_high_r;
        tick_s     = 1'b0;
        min_s      = 1'b0;
        if (clr) begin
            div_cnt_s  = DIV_ZERO;
            sec_low_s  = 4'd0;
            sec_high_s = 4'd0;
        end else if (load) begin
            div_cnt_s  = DIV_ZERO;
            sec_low_s  = clamp_bcd(load_low, 4'd9);
            sec_high_s = clamp_bcd(load_high, 4'd5);
        end else if (run) begin
            if (div_cnt_r == DIV_TERM) begin
                div_cnt_s = DIV_ZERO;
                tick_s    = 1'b1;
                if (sec_low_r < 4'd9) begin
                    sec_low_s = sec_low_r + 4'd1;
                end else begin
                    sec_low_s = 4'd0;
                    if (sec_high_r < 4'd5) begin
                        sec_high_s = sec_high_r + 4'd1;
                    end else begin
                        sec_high_s = 4'd0;
                        min_s      = 1'b1;
                    end
                end
            end else begin
                div_cnt_s = div_cnt_r + DIV_ONE;
            end
        end else begin
            div_cnt_s  = div_cnt_r;
            sec_low_s  = sec_low_r;
            sec_high_s = sec_high_r;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r  <= DIV_ZERO;
            sec_low_r  <= 4'd0;
            sec_high_r <= 4'd0;
            tick_r     <= 1'b0;
            min_r      <= 1'b0;
        end else begin
            div_cnt_r  <= div_cnt_s;
            sec_low_r  <= sec_low_s;
            sec_high_r <= sec_high_s;
            tick_r     <= tick_s;
            min_r      <= min_s;
        end
    end

    assign sec_low  = sec_low_r;
    assign sec_high = sec_high_r;
    assign tick_1hz = tick_r;
    assign clk_min  = min_r;

`ifdef M_GEN_SEC_BLINK_EN
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    logic blink_r;

    // Colon blink: high during the first half of each second, frozen while paused
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            blink_r <= 1'b0;
        end else if (run) begin
            blink_r <= (div_cnt_r < DIV_HALF);
        end else begin
            blink_r <= blink_r;
        end
    end

    assign blink = blink_r;
`else
    assign blink = 1'b0;
`endif

endmodule
